// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding used by the register-bank
// target and the single-register target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDRESS = 3'd1,
        ST_ACK     = 3'd2,
        ST_WRITE_1 = 3'd3,
        ST_WRITE_2 = 3'd4,
        ST_READ_1  = 3'd5,
        ST_READ_2  = 3'd6,
        ST_READ_3  = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Glitch filter for one I2C line: the level moves only after FILTER_LEN equal
// samples, and rise/fall pulse for one cycle when the filtered level changes.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [FILTER_LEN-1:0] sh_q, sh_d;
    logic                  level_q, level_d;
    logic                  prev_q;

    always_comb begin
        sh_d    = {sh_q[FILTER_LEN-2:0], din};
        level_d = level_q;
        if (&sh_q) begin
            level_d = 1'b1;
        end else if (~|sh_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;
    assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C target with a bank of 8-bit registers behind one device address and an
// auto-incrementing register pointer; local logic may also load registers.
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int         FILTER_LEN = 4,
    parameter logic [6:0] DEV_ADDR   = 7'h70,
    parameter int         PTR_W      = 2,
    localparam int        NUM_REGS   = 2 ** PTR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    output logic                  scl_o,
    output logic                  scl_t,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_t,
    input  logic [8*NUM_REGS-1:0] data_in,
    input  logic [NUM_REGS-1:0]   data_latch,
    output logic [8*NUM_REGS-1:0] data_out,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic [PTR_W-1:0]      ptr_out,
    output logic                  busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .din(scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .din(sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_e                   state_q, state_d;
    logic [2:0]                   bit_cnt_q, bit_cnt_d;
    logic [7:0]                   shift_q, shift_d;
    logic                         rw_q, rw_d;
    logic                         ptr_pend_q, ptr_pend_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [NUM_REGS-1:0][7:0]     regs_q, regs_d;
    logic [NUM_REGS-1:0]          wr_strobe_q, wr_strobe_d;
    logic                         busy_q, busy_d;
    logic                         sda_o_q, sda_o_d;
    logic [7:0]                   new_byte;
    logic                         start_det, stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign new_byte  = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_pend_d  = ptr_pend_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        sda_o_d     = sda_o_q;
        wr_strobe_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = data_latch[k] ? data_in[8*k +: 8] : regs_q[k];
        end

        // START/STOP override whatever byte is in flight; the pointer survives both
        if (start_det) begin
            state_d   = ST_ADDRESS;
            bit_cnt_d = 3'd0;
            sda_o_d   = 1'b1;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            sda_o_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDRESS: begin
                    if (scl_rise) begin
                        shift_d   = new_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (new_byte[7:1] == DEV_ADDR) begin
                                state_d    = ST_ACK;
                                busy_d     = 1'b1;
                                rw_d       = new_byte[0];
                                ptr_pend_d = ~new_byte[0];
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_fall) begin
                        sda_o_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = ST_READ_1;
                            shift_d = regs_q[ptr_q];
                        end else begin
                            state_d = ST_WRITE_1;
                        end
                    end
                end
                ST_WRITE_1: begin
                    if (scl_fall) begin
                        sda_o_d   = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WRITE_2;
                    end
                end
                ST_WRITE_2: begin
                    if (scl_rise) begin
                        shift_d   = new_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACK;
                            // First byte of a write selects the register
                            if (ptr_pend_q) begin
                                ptr_d      = new_byte[PTR_W-1:0];
                                ptr_pend_d = 1'b0;
                            end else begin
                                regs_d[ptr_q]      = new_byte;
                                wr_strobe_d[ptr_q] = 1'b1;
                                ptr_d              = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                ST_READ_1: begin
                    if (scl_fall) begin
                        sda_o_d   = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_READ_2;
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end
                end
                ST_READ_2: begin
                    if (scl_fall) begin
                        sda_o_d = 1'b1;
                        state_d = ST_READ_3;
                    end
                end
                ST_READ_3: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            shift_d   = regs_q[ptr_q];
                            bit_cnt_d = 3'd0;
                            state_d   = ST_READ_1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_o_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rw_q        <= 1'b0;
            ptr_pend_q  <= 1'b0;
            ptr_q       <= '0;
            regs_q      <= '0;
            wr_strobe_q <= '0;
            busy_q      <= 1'b0;
            sda_o_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_pend_q  <= ptr_pend_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
            sda_o_q     <= sda_o_d;
        end
    end

    assign scl_o     = 1'b1;
    assign scl_t     = 1'b1;
    assign sda_o     = sda_o_q;
    assign sda_t     = sda_o_q;
    assign data_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign ptr_out   = ptr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: a bit-banged I2C controller drives the bus
// and each observation is checked against hand-computed values.
module tb_i2c_reg_bank;

    localparam int Q = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [31:0] data_in = '0;
    logic [3:0]  data_latch = '0;
    logic        scl_o, scl_t, sda_o, sda_t, busy;
    logic [31:0] data_out;
    logic [3:0]  wr_strobe;
    logic [1:0]  ptr_out;
    logic        sda_line;
    int          total = 0;
    int          bad = 0;
    int          strobe_cnt [4] = '{0, 0, 0, 0};

    assign sda_line = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_reg_bank #(.FILTER_LEN(4), .DEV_ADDR(7'h70), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_line), .sda_o(sda_o), .sda_t(sda_t), .data_in(data_in),
        .data_latch(data_latch), .data_out(data_out), .wr_strobe(wr_strobe),
        .ptr_out(ptr_out), .busy(busy)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_strobe[k]) strobe_cnt[k] <= strobe_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b1; wait_q(1);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_q(1);
        scl_m = 1'b1; wait_q(2);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        b = sda_line; wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(nack);
    endtask

    // Last bit raises local latches to reg1/reg2 and holds them through the commit edge
    task automatic write_byte_collide(input logic [7:0] v, output logic ack_n, output logic seen);
        for (int i = 7; i >= 1; i--) write_bit(v[i]);
        seen = 1'b0;
        sda_m = v[0]; wait_q(1);
        scl_m = 1'b1;
        data_latch = 4'b0110;
        for (int i = 0; i < 2 * Q && !seen; i++) begin
            @(negedge clk);
            if (wr_strobe[1]) seen = 1'b1;
        end
        data_latch = 4'b0000;
        wait_q(1);
        scl_m = 1'b0; wait_q(1);
        read_bit(ack_n);
    endtask

    initial begin
        logic       ack_n;
        logic       b;
        logic       seen;
        logic [7:0] rd;

        #2 rst = 1'b1;
        #1;
        chk("rst_sda_o_async", {31'd0, sda_o}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_sda_o", {31'd0, sda_o}, 32'd1);
        chk("rst_sda_t", {31'd0, sda_t}, 32'd1);
        chk("rst_scl_o", {31'd0, scl_o}, 32'd1);
        chk("rst_scl_t", {31'd0, scl_t}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ptr", {30'd0, ptr_out}, 32'd0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_strobe", {28'd0, wr_strobe}, 32'd0);
        rst = 1'b0;
        wait_q(2);

        // Sequential write with auto-increment
        i2c_start();
        write_byte(8'hE0, ack_n); chk("t1_ack_addr", {31'd0, ack_n}, 32'd0);
        write_byte(8'h01, ack_n); chk("t1_ack_ptr", {31'd0, ack_n}, 32'd0);
        write_byte(8'hA5, ack_n); chk("t1_ack_d0", {31'd0, ack_n}, 32'd0);
        write_byte(8'h5A, ack_n); chk("t1_ack_d1", {31'd0, ack_n}, 32'd0);
        chk("t1_busy_high", {31'd0, busy}, 32'd1);
        i2c_stop();
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        chk("t1_data_out", data_out, 32'h005AA500);
        chk("t1_ptr", {30'd0, ptr_out}, 32'd3);
        chk("t1_strobe1", strobe_cnt[1], 32'd1);
        chk("t1_strobe2", strobe_cnt[2], 32'd1);

        // Pointer wrap from the last register to register 0
        i2c_start();
        write_byte(8'hE0, ack_n); chk("t2_ack_addr", {31'd0, ack_n}, 32'd0);
        write_byte(8'h03, ack_n);
        write_byte(8'h11, ack_n);
        write_byte(8'h22, ack_n); chk("t2_ack_d1", {31'd0, ack_n}, 32'd0);
        i2c_stop();
        chk("t2_data_out", data_out, 32'h115AA522);
        chk("t2_ptr", {30'd0, ptr_out}, 32'd1);
        chk("t2_strobe3", strobe_cnt[3], 32'd1);
        chk("t2_strobe0", strobe_cnt[0], 32'd1);

        // Local load of reg2/reg3, then pointer write + repeated START + read
        data_in = 32'h4433_0000;
        @(negedge clk); data_latch = 4'b1100;
        @(negedge clk); data_latch = 4'b0000;
        @(negedge clk);
        chk("t3_latch", data_out, 32'h4433A522);
        i2c_start();
        write_byte(8'hE0, ack_n);
        write_byte(8'h02, ack_n); chk("t3_ack_ptr", {31'd0, ack_n}, 32'd0);
        chk("t3_ptr_set", {30'd0, ptr_out}, 32'd2);
        i2c_start();
        write_byte(8'hE1, ack_n); chk("t3_ack_raddr", {31'd0, ack_n}, 32'd0);
        read_byte(1'b0, rd); chk("t3_rd0", {24'd0, rd}, 32'h33);
        read_byte(1'b1, rd); chk("t3_rd1", {24'd0, rd}, 32'h44);
        chk("t3_sda_released", {31'd0, sda_o}, 32'd1);
        chk("t3_ptr_wrap", {30'd0, ptr_out}, 32'd0);
        i2c_stop();

        // Wrong device address
        i2c_start();
        write_byte(8'hE2, ack_n); chk("t4_nack", {31'd0, ack_n}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        chk("t4_data_out", data_out, 32'h4433A522);

        // I2C commit collides with local latch of the same register
        data_in = 32'h0066_7700;
        i2c_start();
        write_byte(8'hE0, ack_n);
        write_byte(8'h01, ack_n);
        write_byte_collide(8'h99, ack_n, seen);
        chk("t5_strobe_seen", {31'd0, seen}, 32'd1);
        chk("t5_ack", {31'd0, ack_n}, 32'd0);
        i2c_stop();
        chk("t5_data_out", data_out, 32'h44669922);
        chk("t5_strobe1", strobe_cnt[1], 32'd2);
        chk("t5_strobe2", strobe_cnt[2], 32'd1);
        chk("t5_ptr", {30'd0, ptr_out}, 32'd2);

        // STOP after half a data byte, then reset in the middle of a read
        i2c_start();
        write_byte(8'hE0, ack_n);
        write_byte(8'h00, ack_n);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        chk("t6_partial", data_out, 32'h44669922);
        chk("t6_ptr", {30'd0, ptr_out}, 32'd0);
        chk("t6_strobe1", strobe_cnt[1], 32'd2);
        i2c_start();
        write_byte(8'hE1, ack_n);
        read_bit(b); chk("t6_rd_bit7", {31'd0, b}, 32'd0);
        chk("t6_sda_driven", {31'd0, sda_o}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_sda_o", {31'd0, sda_o}, 32'd1);
        chk("t6_rst_sda_t", {31'd0, sda_t}, 32'd1);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_data", data_out, 32'h0);
        chk("t6_rst_ptr", {30'd0, ptr_out}, 32'd0);
        chk("t6_rst_strobe", {28'd0, wr_strobe}, 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_q(1);
        chk("t6_post_sda", {31'd0, sda_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
I2C target exposing a bank of NUM_REGS 8-bit registers behind one 7-bit device address, with an internal register pointer that auto-increments. It generalises the single-register I2C target: the first written byte selects the register, and later bytes read or write consecutive registers. It sits between the board I2C pins (through tristate buffers) and local logic, which can also load any register in parallel.

Parameters:
FILTER_LEN, 4, glitch-filter length in clk cycles for SCL and SDA (min 2)
DEV_ADDR, 7'h70, 7-bit I2C target address
PTR_W, 2, register pointer width; NUM_REGS = 2**PTR_W (1..8)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
scl_i  input  1  SCL pin level
scl_o  output  1  constant 1 (target never stretches the clock)
scl_t  output  1  constant 1 (SCL tristate released)
sda_i  input  1  SDA pin level
sda_o  output  1  SDA drive value
sda_t  output  1  SDA tristate enable, equal to sda_o (open-drain)
data_in  input  8*NUM_REGS  parallel load data; register k occupies bits [8k+7:8k]
data_latch  input  NUM_REGS  per-register load enable from local logic
data_out  output  8*NUM_REGS  register contents, same packing as data_in
wr_strobe  output  NUM_REGS  one-cycle pulse when an I2C write updates register k
ptr_out  output  PTR_W  current register pointer
busy  output  1  high from address match until STOP, or until a START that fails to match

Behaviour:
- Reset (asynchronous, high): state IDLE; sda_o=sda_t=1; all registers, pointer, wr_strobe and busy are 0; filters clear to 0.
- Filtering: a line level changes only after FILTER_LEN consecutive equal samples. Edges are derived from the filtered level against its previous value. Pin-to-edge latency is FILTER_LEN+1 cycles.
- START = filtered SDA falls while SCL high. STOP = filtered SDA rises while SCL high. Both take priority over every state.
- START in any state (including mid-byte, i.e. a repeated START): go to ADDRESS, release SDA, discard any partial byte. The pointer is kept.
- STOP: go to IDLE, release SDA, busy=0. The pointer is kept.
- States:
  - IDLE.
  - ADDRESS: shift 7 address bits plus R/W on SCL rising edges. On match go to ACK and set busy. On mismatch go to IDLE and clear busy.
  - ACK: on the SCL falling edge drive SDA low, then go to WRITE_1 or READ_1 according to the mode.
  - WRITE_1: release SDA on the next SCL falling edge.
  - WRITE_2: shift 8 bits, then go to ACK.
  - READ_1: shift out the 8 bits MSB first on SCL falling edges.
  - READ_2: release SDA on the SCL falling edge.
  - READ_3: sample the controller ACK on the SCL rising edge. ACK reloads the next byte and returns to READ_1. NACK goes to IDLE.
- Write transaction: the first data byte after the address is the pointer byte; ptr <= byte[PTR_W-1:0] and the upper bits are ignored. Each later byte is committed on the 8th SCL rising edge: reg[ptr] <= byte, wr_strobe[ptr]=1 for exactly that cycle, then ptr <= ptr+1 modulo NUM_REGS. Every byte, including the pointer byte, is ACKed.
- Read transaction: each byte is loaded from reg[ptr] on entry to READ_1. ptr increments modulo NUM_REGS after each byte is shifted out, whether the controller ACKs or NACKs. A read directly after a write with repeated START returns reg[ptr] at the pointer set by that write.
- Wrap-around: ptr = NUM_REGS-1 followed by +1 gives 0.
- Same-cycle I2C commit and data_latch to the same register: the I2C write wins, and the strobe still fires. Latches to other registers in that cycle apply normally.
- data_latch during a read byte does not alter the byte already loaded in the shift register.
- data_out reflects the register one cycle after the update.
- Out-of-range states recover to IDLE.

Decomposition:
- Package i2c_pkg: state encoding constants (IDLE, ADDRESS, ACK, WRITE_1, WRITE_2, READ_1, READ_2, READ_3), shared with the existing I2C target.
- Sub-module i2c_line_filter (parameter FILTER_LEN), instantiated for SCL and SDA. Outputs the filtered level plus rise and fall pulses.
- Top level holds the FSM, pointer and register array.

Test Plan:
- Write 0xE0, 0x01, 0xA5, 0x5A, STOP -> reg1=0xA5, reg2=0x5A, ptr=3; wr_strobe[1] then wr_strobe[2] each high for one cycle; every byte ACKed.
- Write 0xE0, 0x03, 0x11, 0x22, STOP -> reg3=0x11, reg0=0x22 (wrap); ptr=1.
- Write 0xE0, 0x02, repeated START, 0xE1, read 2 bytes with ACK then NACK, with reg2=0x33 and reg3=0x44 -> bytes returned 0x33, 0x44; SDA released after NACK; ptr=0.
- Address 0xE2 (device 0x71) -> no ACK (SDA stays 1), no register change, busy=0.
- data_latch[1] with data_in byte1=0x77 in the same cycle as an I2C commit of 0x99 to reg1 -> reg1=0x99; wr_strobe[1]=1.
- STOP mid-byte after 4 data bits, then assert rst mid-read -> no register update from the partial byte; after rst all outputs are at their reset values and SDA is released immediately.
